// File: rtl/uart_pkg.sv
// Shared frame geometry and receiver state encoding for the UART receive path.
package uart_pkg;

    localparam int FRAME_W = 11;
    localparam int DATA_W  = 8;

    // Bit positions inside an assembled frame (wire order, first bit in the MSB)
    localparam int START_IDX  = 10;
    localparam int D0_IDX     = 9;
    localparam int D7_IDX     = 2;
    localparam int PARITY_IDX = 1;
    localparam int STOP_IDX   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_STOP  = STOP;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a free-running DIV-cycle counter that emits a
// one-cycle tick on wrap. The clear input re-phases the counter so the first
// tick after a start edge lands a fixed number of cycles later.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic os_tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at DIV-1, or restart from zero when re-phased
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign os_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive front end: synchronises rx, validates the start bit at mid-bit,
// assembles start/data/parity/stop into an 11-bit frame and hands it to the
// frame detector over a valid/ack handshake with a sticky overrun flag.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_i,
    input  logic               frame_ack_i,
    output logic [FRAME_W-1:0] data_frame_o,
    output logic               frame_valid_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int            DIV       = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int            SW        = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_W);

    logic               rxMeta_q;
    logic               rxS_q;
    logic               rxD_q;

    logic [1:0]         state_q,     state_d;
    logic [SW-1:0]      sampleCnt_q, sampleCnt_d;
    logic [3:0]         bitCnt_q,    bitCnt_d;
    logic [FRAME_W-1:0] shift_q,     shift_d;
    logic               deliver_q,   deliver_d;

    logic [FRAME_W-1:0] dataFrame_q;
    logic               frameValid_q;
    logic               overrun_q;

    logic               osTick;
    logic               tickClear;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (tickClear),
        .os_tick_o (osTick)
    );

    // Two-flop synchroniser plus a history flop for falling-edge detection; idle high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxMeta_q <= 1'b1;
            rxS_q    <= 1'b1;
            rxD_q    <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxS_q    <= rxMeta_q;
            rxD_q    <= rxS_q;
        end
    end

    // Receive sequencer: only a true falling edge starts a frame, so a held-low
    // line (break, or a zero stop bit that stays low) never restarts reception
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        tickClear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rxD_q && !rxS_q) begin
                    state_d     = ST_START;
                    sampleCnt_d = '0;
                    tickClear   = 1'b1;
                end
            end
            ST_START: begin
                if (osTick) begin
                    if (sampleCnt_q == HALF_LAST) begin
                        sampleCnt_d = '0;
                        if (!rxS_q) begin
                            state_d  = ST_SHIFT;
                            shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
                            bitCnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (osTick) begin
                    if (sampleCnt_q == FULL_LAST) begin
                        sampleCnt_d = '0;
                        shift_d     = {shift_q[FRAME_W-2:0], rxS_q};
                        if (bitCnt_q == LAST_BIT) begin
                            bitCnt_d = '0;
                            state_d  = ST_STOP;
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (osTick) begin
                    if (sampleCnt_q == FULL_LAST) begin
                        sampleCnt_d = '0;
                        shift_d     = {shift_q[FRAME_W-2:0], rxS_q};
                        state_d     = ST_IDLE;
                        deliver_d   = 1'b1;
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, sample/bit counters and the frame shift register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
        end
    end

    // Output handshake: a new frame always wins; overrun is raised only when an
    // unacknowledged frame is overwritten, and any accepted ack clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dataFrame_q  <= '0;
            frameValid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (deliver_q) begin
            dataFrame_q  <= shift_q;
            frameValid_q <= 1'b1;
            if (frameValid_q && !frame_ack_i) begin
                overrun_q <= 1'b1;
            end else if (frameValid_q) begin
                overrun_q <= 1'b0;
            end
        end else if (frameValid_q && frame_ack_i) begin
            frameValid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign data_frame_o  = dataFrame_q;
    assign frame_valid_o = frameValid_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Testbench for uart_rx_sequencer at 160 clocks per bit (DIV=10, 16x oversample).
module tb_uart_rx_sequencer;

    localparam int CLK_HZ     = 1_536_000;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CYC    = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        frameAck;
    logic [10:0] dataFrame;
    logic        frameValid;
    logic        busy;
    logic        overrun;

    int          nVectors     = 0;
    int          nMiscompares = 0;
    logic [10:0] expQ[$];

    always #5 clk = ~clk;

    uart_rx_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_i          (rx),
        .frame_ack_i   (frameAck),
        .data_frame_o  (dataFrame),
        .frame_valid_o (frameValid),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    // Reference frame: start, d0..d7 (LSB first), even parity (optionally flipped), stop
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic parErr,
                                               input logic stopBit);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9-i] = d[i];
        f[1] = (^d) ^ parErr;
        f[0] = stopBit;
        return f;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic parErr, input logic stopBit);
        logic [10:0] f;
        f = make_frame(d, parErr, stopBit);
        expQ.push_back(f);
        for (int i = 10; i >= 0; i--) drive_bit(f[i]);
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (frameValid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ack();
        frameAck = 1'b1;
        @(negedge clk);
        frameAck = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; frameAck = 1'b0;
        idle_cycles(3);
        nVectors++;
        if (dataFrame !== 11'h000) begin nMiscompares++; $display("[TB] FAIL reset_data: got %h expected 000", dataFrame); end
        nVectors++;
        if (frameValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", frameValid); end
        nVectors++;
        if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nVectors++;
        if (overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        rst = 1'b0;
        idle_cycles(BIT_CYC);
    endtask

    task automatic test_basic();
        bit          seen;
        logic [10:0] exp;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_valid(seen);
        nVectors++;
        if (!seen) begin nMiscompares++; $display("[TB] FAIL basic_valid: got timeout expected frame_valid=1"); end
        exp = expQ.pop_front();
        nVectors++;
        if (dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL basic_data: got %h expected %h", dataFrame, exp); end
        nVectors++;
        if (dataFrame !== 11'h295) begin nMiscompares++; $display("[TB] FAIL basic_A5: got %h expected 295", dataFrame); end
        nVectors++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_flags: got ovr=%b busy=%b expected 0 0", overrun, busy); end
        idle_cycles(50);
        nVectors++;
        if (frameValid !== 1'b1 || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL basic_hold: got v=%b %h expected v=1 %h", frameValid, dataFrame, exp); end
        do_ack();
        nVectors++;
        if (frameValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_ack: got %b expected 0", frameValid); end
        idle_cycles(BIT_CYC);
    endtask

    task automatic test_patterns();
        logic [7:0]  pats[4];
        logic [10:0] exp;
        bit          seen;
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h3C; pats[3] = 8'($urandom_range(0, 255));
        for (int p = 0; p < 4; p++) begin
            send_frame(pats[p], 1'b0, 1'b1);
            wait_valid(seen);
            exp = expQ.pop_front();
            nVectors++;
            if (!seen || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL pattern_%0d: got v=%b %h expected v=1 %h", p, frameValid, dataFrame, exp); end
            do_ack();
            nVectors++;
            if (frameValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL pattern_ack_%0d: got %b expected 0", p, frameValid); end
            idle_cycles(BIT_CYC);
        end
    endtask

    task automatic test_bad_parity();
        bit          seen;
        logic [10:0] exp;
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_valid(seen);
        exp = expQ.pop_front();
        nVectors++;
        if (!seen || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL parity_data: got v=%b %h expected v=1 %h", frameValid, dataFrame, exp); end
        nVectors++;
        if (dataFrame !== 11'h297) begin nMiscompares++; $display("[TB] FAIL parity_297: got %h expected 297", dataFrame); end
        do_ack();
        idle_cycles(BIT_CYC);
    endtask

    task automatic test_break();
        bit          seen;
        logic [10:0] exp;
        int          busyCycles;
        int          validCycles;
        send_frame(8'h81, 1'b0, 1'b0);
        wait_valid(seen);
        exp = expQ.pop_front();
        nVectors++;
        if (!seen || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL break_data: got v=%b %h expected v=1 %h", frameValid, dataFrame, exp); end
        nVectors++;
        if (dataFrame[0] !== 1'b0) begin nMiscompares++; $display("[TB] FAIL break_stop: got %b expected 0", dataFrame[0]); end
        do_ack();
        busyCycles = 0; validCycles = 0;
        for (int i = 0; i < 3 * BIT_CYC; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busyCycles++;
            if (frameValid !== 1'b0) validCycles++;
        end
        nVectors++;
        if (busyCycles != 0 || validCycles != 0) begin nMiscompares++; $display("[TB] FAIL break_restart: got busy=%0d valid=%0d cycles expected 0 0", busyCycles, validCycles); end
        rx = 1'b1;
        idle_cycles(2 * BIT_CYC);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_valid(seen);
        exp = expQ.pop_front();
        nVectors++;
        if (!seen || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL break_recover: got v=%b %h expected v=1 %h", frameValid, dataFrame, exp); end
        do_ack();
        idle_cycles(BIT_CYC);
    endtask

    task automatic test_false_start();
        bit busySeen;
        bit validSeen;
        busySeen = 1'b0; validSeen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busySeen = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frameValid !== 1'b0) validSeen = 1'b1;
        end
        nVectors++;
        if (busySeen !== 1'b1) begin nMiscompares++; $display("[TB] FAIL false_busy_pulse: got %b expected 1", busySeen); end
        nVectors++;
        if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL false_busy_end: got %b expected 0", busy); end
        nVectors++;
        if (validSeen !== 1'b0) begin nMiscompares++; $display("[TB] FAIL false_valid: got %b expected 0", validSeen); end
    endtask

    task automatic test_back_to_back();
        bit          seen;
        logic [10:0] exp;
        send_frame(8'h12, 1'b0, 1'b1);
        exp = expQ.pop_front();
        nVectors++;
        if (frameValid !== 1'b1 || dataFrame !== exp || overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_first: got v=%b %h ovr=%b expected v=1 %h ovr=0", frameValid, dataFrame, overrun, exp); end
        send_frame(8'hE7, 1'b0, 1'b1);
        wait_valid(seen);
        exp = expQ.pop_front();
        nVectors++;
        if (!seen || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL b2b_second: got v=%b %h expected v=1 %h", frameValid, dataFrame, exp); end
        nVectors++;
        if (overrun !== 1'b1) begin nMiscompares++; $display("[TB] FAIL b2b_overrun: got %b expected 1", overrun); end
        do_ack();
        nVectors++;
        if (frameValid !== 1'b0 || overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_ack: got v=%b ovr=%b expected 0 0", frameValid, overrun); end
        idle_cycles(BIT_CYC);
    endtask

    task automatic test_reset_mid();
        bit          seen;
        logic [10:0] exp;
        logic [10:0] f;
        send_frame(8'h66, 1'b0, 1'b1);
        wait_valid(seen);
        exp = expQ.pop_front();
        nVectors++;
        if (!seen || dataFrame !== exp) begin nMiscompares++; $display("[TB] FAIL rstmid_pre: got v=%b %h expected v=1 %h", frameValid, dataFrame, exp); end
        f = make_frame(8'hF0, 1'b0, 1'b1);
        for (int i = 10; i >= 6; i--) drive_bit(f[i]);
        rx = f[5];
        idle_cycles(80);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        nVectors++;
        if (dataFrame !== 11'h000 || frameValid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL rstmid_outputs: got %h v=%b b=%b o=%b expected 000 0 0 0", dataFrame, frameValid, busy, overrun);
        end
        rst = 1'b0;
        idle_cycles(2 * BIT_CYC);
        send_frame(8'hC3, 1'b0, 1'b1);
        wait_valid(seen);
        exp = expQ.pop_front();
        nVectors++;
        if (!seen || dataFrame !== exp || overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rstmid_after: got v=%b %h ovr=%b expected v=1 %h ovr=0", frameValid, dataFrame, overrun, exp); end
        do_ack();
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: got cycle budget exhausted expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_bad_parity();
        test_break();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        nVectors++;
        if (expQ.size() != 0) begin nMiscompares++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
